rv32_multicycle_hs: RTL and testbench

//  Multicycle RV32I core (RV32E when NREGS=16). One unified 32-bit memory port with a
//  req/ready handshake, so memory latency is variable. Byte-lane write strobes.

---
 rtl/rv32_multicycle_hs.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_rv32_multicycle_hs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_hs.sv
// Multicycle RV32I core (RV32E when NREGS=16) with a single req/ready memory port.
// Optional feature macro RV_CYCLE_CSR_EN: cycle/instret counters readable via CSRRS rd, csr, x0.
module rv32_multicycle_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_halted,
  output logic [1:0]  o_halt_cause
);
  localparam int unsigned AW  = $clog2(NREGS);
  localparam bit          RvE = (NREGS == 16);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StHalt} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [1:0]  r_ls_lo;
  logic [31:0] r_rf [NREGS];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1_idx, w_rs2_idx;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode  = r_instr[6:0];
  assign w_rd      = r_instr[11:7];
  assign w_f3      = r_instr[14:12];
  assign w_rs1_idx = r_instr[19:15];
  assign w_rs2_idx = r_instr[24:20];
  assign w_f7      = r_instr[31:25];
  assign w_imm_i   = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s   = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b   = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                      r_instr[11:8], 1'b0};
  assign w_imm_u   = {r_instr[31:12], 12'b0};
  assign w_imm_j   = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                      r_instr[30:21], 1'b0};

  logic w_csr_ok;
  logic [31:0] w_csr_val;
`ifdef RV_CYCLE_CSR_EN
  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  always_comb begin
    w_csr_ok  = (w_f3 == 3'b010) && (w_rs1_idx == 5'd0);
    w_csr_val = 32'b0;
    case (r_instr[31:20])
      12'hC00: w_csr_val = r_cycle[31:0];
      12'hC80: w_csr_val = r_cycle[63:32];
      12'hC02: w_csr_val = r_instret[31:0];
      12'hC82: w_csr_val = r_instret[63:32];
      default: w_csr_ok  = 1'b0;
    endcase
  end
`else
  assign w_csr_ok  = 1'b0;
  assign w_csr_val = 32'b0;
`endif

  logic w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_ridx_bad;
  always_comb begin
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OpLui, OpAuipc, OpJal: begin w_legal = 1'b1; w_use_rd = 1'b1; end
      OpJalr:   begin w_legal = (w_f3 == 3'b000); w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OpBranch: begin
        w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OpLoad: begin
        w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      OpStore: begin w_legal = (w_f3 <= 3'b010); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OpImm: begin
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        else                     w_legal = 1'b1;
        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      OpReg: begin
        w_legal = (w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OpFence: w_legal = 1'b1;
      OpSystem: begin
        w_legal  = (r_instr == 32'h0000_0073) || (r_instr == 32'h0010_0073) || w_csr_ok;
        w_use_rd = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    // Only RV32E can name a register that does not exist.
    w_ridx_bad = RvE && ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1_idx[4]) ||
                         (w_use_rs2 && w_rs2_idx[4]));
  end

  logic [31:0] w_op_b, w_alu, w_wb_val, w_next_pc, w_ls_addr, w_st_data, w_ld_sh, w_ld_val;
  logic [4:0]  w_shamt;
  logic [3:0]  w_strb;
  logic        w_taken, w_wb_en, w_is_env, w_is_ls, w_is_st, w_misal;

  always_comb begin
    w_op_b  = (w_opcode == OpReg) ? r_rs2 : w_imm_i;
    w_shamt = w_op_b[4:0];
    case (w_f3)
      3'b000:  w_alu = ((w_opcode == OpReg) && w_f7[5]) ? r_rs1 - w_op_b : r_rs1 + w_op_b;
      3'b001:  w_alu = r_rs1 << w_shamt;
      3'b010:  w_alu = {31'b0, $signed(r_rs1) < $signed(w_op_b)};
      3'b011:  w_alu = {31'b0, r_rs1 < w_op_b};
      3'b100:  w_alu = r_rs1 ^ w_op_b;
      3'b101:  w_alu = w_f7[5] ? 32'($signed(r_rs1) >>> w_shamt) : r_rs1 >> w_shamt;
      3'b110:  w_alu = r_rs1 | w_op_b;
      default: w_alu = r_rs1 & w_op_b;
    endcase

    case (w_f3)
      3'b000:  w_taken = (r_rs1 == r_rs2);
      3'b001:  w_taken = (r_rs1 != r_rs2);
      3'b100:  w_taken = $signed(r_rs1) < $signed(r_rs2);
      3'b101:  w_taken = $signed(r_rs1) >= $signed(r_rs2);
      3'b110:  w_taken = r_rs1 < r_rs2;
      3'b111:  w_taken = r_rs1 >= r_rs2;
      default: w_taken = 1'b0;
    endcase

    w_next_pc = r_pc + 32'd4;
    w_wb_val  = w_alu;
    case (w_opcode)
      OpLui:    w_wb_val = w_imm_u;
      OpAuipc:  w_wb_val = r_pc + w_imm_u;
      OpJal:    begin w_wb_val = r_pc + 32'd4; w_next_pc = r_pc + w_imm_j; end
      OpJalr:   begin w_wb_val = r_pc + 32'd4; w_next_pc = (r_rs1 + w_imm_i) & ~32'd1; end
      OpBranch: if (w_taken) w_next_pc = r_pc + w_imm_b;
      OpSystem: w_wb_val = w_csr_val;
      default:  ;
    endcase
    w_wb_en  = w_opcode inside {OpLui, OpAuipc, OpJal, OpJalr, OpImm, OpReg, OpSystem};
    w_is_env = (w_opcode == OpSystem) && (w_f3 == 3'b000);
    w_is_st  = (w_opcode == OpStore);
    w_is_ls  = w_is_st || (w_opcode == OpLoad);

    w_ls_addr = r_rs1 + (w_is_st ? w_imm_s : w_imm_i);
    w_misal   = ((w_f3[1:0] == 2'b01) && w_ls_addr[0]) ||
                ((w_f3[1:0] == 2'b10) && (w_ls_addr[1:0] != 2'b00));
    case (w_f3[1:0])
      2'b00:   begin w_strb = 4'b0001 << w_ls_addr[1:0]; w_st_data = {4{r_rs2[7:0]}}; end
      2'b01:   begin
        w_strb = 4'b0011 << {w_ls_addr[1], 1'b0}; w_st_data = {2{r_rs2[15:0]}};
      end
      default: begin w_strb = 4'b1111; w_st_data = r_rs2; end
    endcase

    w_ld_sh = i_mem_rdata >> {r_ls_lo, 3'b000};
    case (w_f3)
      3'b000:  w_ld_val = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
      3'b001:  w_ld_val = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
      3'b100:  w_ld_val = {24'b0, w_ld_sh[7:0]};
      3'b101:  w_ld_val = {16'b0, w_ld_sh[15:0]};
      default: w_ld_val = i_mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_instr      <= 32'b0;
      r_rs1        <= 32'b0;
      r_rs2        <= 32'b0;
      r_ls_lo      <= 2'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= 32'b0;
      o_mem_wstrb  <= 4'b0;
      o_mem_wdata  <= 32'b0;
      o_halted     <= 1'b0;
      o_halt_cause <= 2'b00;
    end else begin
      case (r_state)
        StFetch: begin
          if (!o_mem_req) begin
            o_mem_req   <= 1'b1;
            o_mem_addr  <= {r_pc[31:2], 2'b00};
            o_mem_we    <= 1'b0;
            o_mem_wstrb <= 4'b0;
          end else if (i_mem_ready) begin
            r_instr   <= i_mem_rdata;
            o_mem_req <= 1'b0;
            r_state   <= StDecode;
          end
        end
        StDecode: begin
          if (!w_legal || w_ridx_bad) begin
            r_state <= StHalt; o_halted <= 1'b1; o_halt_cause <= 2'b11;
          end else begin
            r_rs1   <= (w_rs1_idx == 5'd0) ? 32'b0 : r_rf[w_rs1_idx[AW-1:0]];
            r_rs2   <= (w_rs2_idx == 5'd0) ? 32'b0 : r_rf[w_rs2_idx[AW-1:0]];
            r_state <= StExec;
          end
        end
        StExec: begin
          if (w_is_env) begin
            r_state <= StHalt; o_halted <= 1'b1; o_halt_cause <= 2'b01;
          end else if (w_is_ls) begin
            if (w_misal) begin
              r_state <= StHalt; o_halted <= 1'b1; o_halt_cause <= 2'b10;
            end else begin
              r_pc        <= r_pc + 32'd4;
              o_mem_req   <= 1'b1;
              o_mem_addr  <= {w_ls_addr[31:2], 2'b00};
              o_mem_we    <= w_is_st;
              o_mem_wstrb <= w_is_st ? w_strb : 4'b0;
              o_mem_wdata <= w_is_st ? w_st_data : 32'b0;
              r_ls_lo     <= w_ls_addr[1:0];
              r_state     <= StMem;
            end
          end else begin
            if (w_wb_en && (w_rd != 5'd0)) r_rf[w_rd[AW-1:0]] <= w_wb_val;
            r_pc        <= w_next_pc;
            o_mem_req   <= 1'b1;
            o_mem_addr  <= {w_next_pc[31:2], 2'b00};
            o_mem_we    <= 1'b0;
            o_mem_wstrb <= 4'b0;
            r_state     <= StFetch;
          end
        end
        StMem: begin
          if (i_mem_ready) begin
            if (!w_is_st && (w_rd != 5'd0)) r_rf[w_rd[AW-1:0]] <= w_ld_val;
            // Chain straight into the next fetch; pc already advanced in EXEC.
            o_mem_addr  <= {r_pc[31:2], 2'b00};
            o_mem_we    <= 1'b0;
            o_mem_wstrb <= 4'b0;
            r_state     <= StFetch;
          end
        end
        default: o_mem_req <= 1'b0;
      endcase
    end
  end

`ifdef RV_CYCLE_CSR_EN
  logic w_retire;
  assign w_retire = ((r_state == StExec) && !w_is_env && !w_is_ls) ||
                    ((r_state == StMem) && i_mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle   <= 64'b0;
      r_instret <= 64'b0;
    end else begin
      if (r_state != StHalt) r_cycle <= r_cycle + 64'd1;
      if (w_retire) r_instret <= r_instret + 64'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rv32_multicycle_hs.sv
// Directed self-checking bench for rv32_multicycle_hs with a wait-state-programmable RAM model.
module tb_rv32_multicycle_hs;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  halt_cause;

  always #5 clk = ~clk;

  rv32_multicycle_hs #(.RESET_PC(32'h0000_0100), .NREGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wstrb (mem_wstrb),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ready (mem_ready),
    .o_halted    (halted),
    .o_halt_cause(halt_cause)
  );

  logic [31:0] mem [256];
  int          waits = 0;
  int          wait_cnt = 0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = 8'd0;
  logic [31:0] ld_data = 32'd0;

  int          n_hs = 0, n_st = 0, n_viol = 0;
  logic [31:0] st_addr [2];
  logic [31:0] st_data [2];
  logic [3:0]  st_strb [2];
  logic        prev_stall = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;
  logic [3:0]  prev_strb = 4'd0;

  assign mem_ready = mem_req && (wait_cnt == waits);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_ready && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
    if (reset) begin
      n_hs <= 0; n_st <= 0; n_viol <= 0; prev_stall <= 1'b0;
    end else begin
      if (mem_req && mem_ready) begin
        n_hs <= n_hs + 1;
        if (mem_we) begin
          if (n_st < 2) begin
            st_addr[n_st[0]] <= mem_addr;
            st_data[n_st[0]] <= mem_wdata;
            st_strb[n_st[0]] <= mem_wstrb;
          end
          n_st <= n_st + 1;
        end
      end
      if (prev_stall && (!mem_req || mem_addr != prev_addr || mem_we != prev_we ||
                         mem_wstrb != prev_strb || mem_wdata != prev_data))
        n_viol <= n_viol + 1;
      prev_stall <= mem_req && !mem_ready;
      prev_addr  <= mem_addr;
      prev_we    <= mem_we;
      prev_strb  <= mem_wstrb;
      prev_data  <= mem_wdata;
    end
  end

  int n_chk = 0, n_pass = 0;
  logic [31:0] prog [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = 8'(idx); ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Holds reset while loading the program at 0x100 and zeroing 0x200..0x23F.
  task automatic boot();
    reset = 1'b1;
    step();
    for (int i = 0; i < 16; i++) ld(128 + i, 32'd0);
    for (int i = 0; i < prog.size(); i++) ld(64 + i, prog[i]);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halted; i++) step();
    check("halted", {31'b0, halted}, 32'd1);
  endtask

  initial begin
    // Program A: ALU, loads/stores, branch, jal, ends with ecall at 0x170.
    prog = '{32'h00500093, 32'hFF908113, 32'h20000093, 32'h112233B7, 32'h34438393,
             32'h0070A023, 32'h00108183, 32'h0020D203, 32'h0AB00293, 32'h005081A3,
             32'h0020A223, 32'h0030A423, 32'h0040A623, 32'h40418433, 32'h40115493,
             32'h00415513, 32'h0080A823, 32'h0090AA23, 32'h00A0AC23, 32'h00100593,
             32'h00009463, 32'h00200593, 32'h0080066F, 32'h00300593, 32'h00B0AE23,
             32'h02C0A023, 32'h00900013, 32'h0200A223, 32'h00000073};
    waits = 0;
    boot();
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("zw_req_c%0d", c), {31'b0, mem_req}, {31'b0, (c % 3) == 1});
      if (c == 1) check("zw_addr_c1", mem_addr, 32'h100);
      if (c == 4) check("zw_addr_c4", mem_addr, 32'h104);
      if (c == 7) check("zw_addr_c7", mem_addr, 32'h108);
    end
    wait_halt(400);
    check("a_cause", {30'b0, halt_cause}, 32'd1);
    check("a_pc", dut.r_pc, 32'h170);
    check("a_handshakes", n_hs, 32'd40);
    check("sw_addr", st_addr[0], 32'h200);
    check("sw_strb", {28'b0, st_strb[0]}, 32'hF);
    check("sw_data", st_data[0], 32'h11223344);
    check("sb_strb", {28'b0, st_strb[1]}, 32'h8);
    check("sb_data", {24'b0, st_data[1][31:24]}, 32'hAB);
    check("m200_sw_sb", mem[128], 32'hAB223344);
    check("m204_addi_neg", mem[129], 32'hFFFFFFFE);
    check("m208_lb", mem[130], 32'h00000033);
    check("m20c_lhu", mem[131], 32'h00001122);
    check("m210_sub", mem[132], 32'hFFFFEF11);
    check("m214_srai", mem[133], 32'hFFFFFFFF);
    check("m218_srli", mem[134], 32'h0FFFFFFF);
    check("m21c_branch", mem[135], 32'h00000001);
    check("m220_jal_link", mem[136], 32'h0000015C);
    check("m224_x0", mem[137], 32'h00000000);
    step(); step();
    check("a_no_req_halted", {31'b0, mem_req}, 32'd0);

    // Same program with three wait states per access.
    waits = 3;
    boot();
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("ws_req_c%0d", c), {31'b0, mem_req}, {31'b0, (c <= 4) || (c == 7)});
      if (c == 4) check("ws_addr_c4", mem_addr, 32'h100);
      if (c == 7) check("ws_addr_c7", mem_addr, 32'h104);
    end
    wait_halt(1500);
    check("ws_stable", n_viol, 32'd0);
    check("ws_m200", mem[128], 32'hAB223344);
    check("ws_m208_lb", mem[130], 32'h00000033);
    check("ws_m20c_lhu", mem[131], 32'h00001122);

    // lw x6,2(x0): misaligned, no data request.
    waits = 0;
    prog = '{32'h00202303};
    boot();
    wait_halt(50);
    check("mis_cause", {30'b0, halt_cause}, 32'd2);
    check("mis_pc", dut.r_pc, 32'h100);
    check("mis_handshakes", n_hs, 32'd1);

    prog = '{32'h0000007F};
    boot();
    wait_halt(50);
    check("ill_cause", {30'b0, halt_cause}, 32'd3);

    // addi x1,x0,0x202; sh x1,0(x1); ecall
    prog = '{32'h20200093, 32'h00109023, 32'h00000073};
    boot();
    wait_halt(50);
    check("sh_addr", st_addr[0], 32'h200);
    check("sh_strb", {28'b0, st_strb[0]}, 32'hC);
    check("sh_data", {16'b0, st_data[0][31:16]}, 32'h0202);
    check("sh_mem", mem[128], 32'h02020000);

`ifdef RV_CYCLE_CSR_EN
    // rdcycle x1; rdcycle x2; sub x3,x2,x1; nop; rdinstret x4; sw x3/x4; ecall
    prog = '{32'hC00020F3, 32'hC0002173, 32'h401101B3, 32'h00000013, 32'hC0202273,
             32'h20302023, 32'h20402223, 32'h00000073};
    boot();
    wait_halt(100);
    check("csr_cycle_delta", mem[128], 32'd3);
    check("csr_instret", mem[129], 32'd4);
`else
    prog = '{32'hC00020F3};
    boot();
    wait_halt(50);
    check("csr_off_cause", {30'b0, halt_cause}, 32'd3);
`endif

    // Reset while a store waits on memory.
    waits = 3;
    prog = '{32'h20000093, 32'h0000A023, 32'h00000073};
    boot();
    for (int i = 0; i < 200 && !(mem_req && mem_we); i++) step();
    check("rstmem_in_store", {31'b0, mem_req && mem_we}, 32'd1);
    reset = 1'b1;
    step();
    check("rstmem_req_drop", {31'b0, mem_req}, 32'd0);
    reset = 1'b0;
    step();
    check("rstmem_refetch_req", {31'b0, mem_req}, 32'd1);
    check("rstmem_refetch_addr", mem_addr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
